stall_controller: RTL and testbench

//  Central pipeline stall/bubble sequencer for the 5-stage core. Merges the
//  one-cycle load-use interlock with a multi-cycle mult/div interlock driven
//  by a small FSM that launches the multdiv unit and holds F/D/X until

---
 rtl/stall_controller.sv | 142 ++++++++++++++
 tb/tb_stall_controller.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stall_controller.sv
`default_nettype none
// ============================================================================
// stall_controller: pipeline stall/bubble sequencer that combines the
// load-use interlock with a multi-cycle mult/div hold FSM.
// Revision: 1.0
// ============================================================================
module stall_controller #(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] op_D,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [4:0] op_X,
  input  logic [4:0] aluop_X,
  input  logic [4:0] rd_X,
  input  logic       flush_X,
  input  logic       multdiv_rdy,
  output logic       stall_front,
  output logic       stall_DX,
  output logic       bubble_DX,
  output logic       bubble_XM,
  output logic       ctrl_MULT,
  output logic       ctrl_DIV,
  output logic       md_busy,
  output logic       timeout_err
);

  localparam logic [4:0] OP_RTYPE  = 5'b00000;
  localparam logic [4:0] OP_SW     = 5'b00111;
  localparam logic [4:0] OP_LW     = 5'b01000;
  localparam logic [4:0] ALU_MULT  = 5'b00110;
  localparam logic [4:0] ALU_DIV   = 5'b00111;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             md_X;
  logic             load_use;
  logic             set_timeout;
  logic             sf_raw, sdx_raw, bdx_raw, bxm_raw, mult_raw, div_raw;

  assign md_X = (op_X == OP_RTYPE) && ((aluop_X == ALU_MULT) || (aluop_X == ALU_DIV));

  // Stores read rt as data, not an address operand, so rt only interlocks for non-sw.
  assign load_use = (op_X == OP_LW) && (rd_X != 5'd0) &&
                    ((rs_D == rd_X) || ((rt_D == rd_X) && (op_D != OP_SW)));

  always_comb begin
    next_state  = state;
    set_timeout = 1'b0;
    sf_raw      = 1'b0;
    sdx_raw     = 1'b0;
    bdx_raw     = 1'b0;
    bxm_raw     = 1'b0;
    mult_raw    = 1'b0;
    div_raw     = 1'b0;
    case (state)
      S_IDLE: begin
        if (md_X && !flush_X) begin
          next_state = S_START;
          sf_raw     = 1'b1;
          sdx_raw    = 1'b1;
          bxm_raw    = 1'b1;
        end else if (load_use && !flush_X) begin
          sf_raw  = 1'b1;
          bdx_raw = 1'b1;
        end
      end
      S_START: begin
        next_state = S_WAIT;
        mult_raw   = !is_div;
        div_raw    = is_div;
        sf_raw     = 1'b1;
        sdx_raw    = 1'b1;
        bxm_raw    = 1'b1;
      end
      S_WAIT: begin
        sf_raw  = 1'b1;
        sdx_raw = 1'b1;
        bxm_raw = 1'b1;
        if (multdiv_rdy) begin
          next_state = S_DONE;
        end else if (cnt == CNT_LAST) begin
          next_state  = S_DONE;
          set_timeout = 1'b1;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && next_state == S_START) begin
        is_div <= (aluop_X == ALU_DIV);
      end
      if (state == S_START) begin
        cnt <= '0;
      end else if (state == S_WAIT && cnt != CNT_SAT) begin
        cnt <= cnt + 1'b1;
      end
      if (set_timeout) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // IDLE-state outputs decode live inputs, so mask them while reset is held.
  assign stall_front = sf_raw   & ~reset;
  assign stall_DX    = sdx_raw  & ~reset;
  assign bubble_DX   = bdx_raw  & ~reset;
  assign bubble_XM   = bxm_raw  & ~reset;
  assign ctrl_MULT   = mult_raw & ~reset;
  assign ctrl_DIV    = div_raw  & ~reset;
  assign md_busy     = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_stall_controller.sv
`default_nettype none
// Directed bench for stall_controller: load-use, mult/div hold, timeout, flush, reset.
module tb_stall_controller;

  logic       clock;
  logic       reset;
  logic [4:0] op_D, rs_D, rt_D, op_X, aluop_X, rd_X;
  logic       flush_X, multdiv_rdy;
  logic       stall_front, stall_DX, bubble_DX, bubble_XM;
  logic       ctrl_MULT, ctrl_DIV, md_busy, timeout_err;

  int checks   = 0;
  int failures = 0;

  stall_controller #(.MAX_CYCLES(40), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .op_D(op_D), .rs_D(rs_D), .rt_D(rt_D),
    .op_X(op_X), .aluop_X(aluop_X), .rd_X(rd_X),
    .flush_X(flush_X), .multdiv_rdy(multdiv_rdy),
    .stall_front(stall_front), .stall_DX(stall_DX),
    .bubble_DX(bubble_DX), .bubble_XM(bubble_XM),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .md_busy(md_busy), .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    op_D = 5'd0; rs_D = 5'd0; rt_D = 5'd0;
    op_X = 5'd0; aluop_X = 5'd0; rd_X = 5'd0;
    flush_X = 1'b0; multdiv_rdy = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    aluop_X = 5'b00110;  // mul sitting in X while reset is held
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({stall_front, stall_DX, bubble_DX, bubble_XM, ctrl_MULT, ctrl_DIV, md_busy, timeout_err} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%b expected=00000000",
               {stall_front, stall_DX, bubble_DX, bubble_XM, ctrl_MULT, ctrl_DIV, md_busy, timeout_err});
    end
    clear_inputs();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load_use;
    // lw r3 in X, add using rs=3 in D
    op_X = 5'b01000; rd_X = 5'd3; op_D = 5'b00000; rs_D = 5'd3; rt_D = 5'd4;
    #1;
    checks++;
    if ({stall_front, bubble_DX, stall_DX, bubble_XM, md_busy} !== 5'b11000) begin
      failures++;
      $display("FAIL load_use_rs got=%b expected=11000", {stall_front, bubble_DX, stall_DX, bubble_XM, md_busy});
    end
    tick();
    // bubble now in X: stall lasts exactly one cycle
    op_X = 5'd0; rd_X = 5'd0;
    #1;
    checks++;
    if ({stall_front, bubble_DX} !== 2'b00) begin
      failures++;
      $display("FAIL load_use_one_cycle got=%b expected=00", {stall_front, bubble_DX});
    end
    tick();
    // rt dependence on a non-store also interlocks
    op_X = 5'b01000; rd_X = 5'd3; op_D = 5'b00000; rs_D = 5'd5; rt_D = 5'd3;
    #1;
    checks++;
    if ({stall_front, bubble_DX} !== 2'b11) begin
      failures++;
      $display("FAIL load_use_rt got=%b expected=11", {stall_front, bubble_DX});
    end
    tick();
    // sw with rt=3: no stall
    op_D = 5'b00111;
    #1;
    checks++;
    if ({stall_front, bubble_DX} !== 2'b00) begin
      failures++;
      $display("FAIL sw_rt_no_stall got=%b expected=00", {stall_front, bubble_DX});
    end
    tick();
    // rd_X = 0 never interlocks
    op_D = 5'b00000; rd_X = 5'd0; rs_D = 5'd0; rt_D = 5'd0;
    #1;
    checks++;
    if ({stall_front, bubble_DX} !== 2'b00) begin
      failures++;
      $display("FAIL rd0_no_stall got=%b expected=00", {stall_front, bubble_DX});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_flush;
    op_X = 5'b01000; rd_X = 5'd3; rs_D = 5'd3; flush_X = 1'b1;
    #1;
    checks++;
    if ({stall_front, bubble_DX} !== 2'b00) begin
      failures++;
      $display("FAIL flush_load_use got=%b expected=00", {stall_front, bubble_DX});
    end
    tick();
    clear_inputs();
    aluop_X = 5'b00110; flush_X = 1'b1;
    #1;
    checks++;
    if ({stall_front, stall_DX, bubble_XM} !== 3'b000) begin
      failures++;
      $display("FAIL flush_md_no_stall got=%b expected=000", {stall_front, stall_DX, bubble_XM});
    end
    tick();
    checks++;
    if (md_busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_md_stays_idle got=%b expected=0", md_busy);
    end
    clear_inputs();
    tick();
  endtask

  // mul in X, rdy on the 10th WAIT cycle (cycle 11 counting detect as 0)
  task automatic test_mul;
    int stall_cycles, sdx_cycles, mult_pulses, div_pulses, pulse_cyc;
    stall_cycles = 0; sdx_cycles = 0; mult_pulses = 0; div_pulses = 0; pulse_cyc = -1;
    aluop_X = 5'b00110;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc == 13) aluop_X = 5'd0;
      multdiv_rdy = (cyc == 11);
      #1;
      if (stall_front) stall_cycles++;
      if (stall_DX && bubble_XM) sdx_cycles++;
      if (ctrl_MULT) begin mult_pulses++; pulse_cyc = cyc; end
      if (ctrl_DIV) div_pulses++;
      if (cyc == 0) begin
        checks++;
        if ({stall_front, stall_DX, bubble_XM, ctrl_MULT, md_busy} !== 5'b11100) begin
          failures++;
          $display("FAIL mul_detect got=%b expected=11100", {stall_front, stall_DX, bubble_XM, ctrl_MULT, md_busy});
        end
      end
      if (cyc == 12) begin
        checks++;
        if ({stall_front, stall_DX, bubble_XM, bubble_DX, md_busy} !== 5'b00001) begin
          failures++;
          $display("FAIL mul_done got=%b expected=00001", {stall_front, stall_DX, bubble_XM, bubble_DX, md_busy});
        end
      end
      if (cyc == 13) begin
        checks++;
        if (md_busy !== 1'b0) begin
          failures++;
          $display("FAIL mul_back_idle got=%b expected=0", md_busy);
        end
      end
      tick();
    end
    checks++;
    if (stall_cycles != 12 || sdx_cycles != 12) begin
      failures++;
      $display("FAIL mul_freeze_len got=%0d/%0d expected=12/12", stall_cycles, sdx_cycles);
    end
    checks++;
    if (mult_pulses != 1 || pulse_cyc != 1 || div_pulses != 0) begin
      failures++;
      $display("FAIL mul_pulse got=%0d@%0d div=%0d expected=1@1 div=0", mult_pulses, pulse_cyc, div_pulses);
    end
    clear_inputs();
  endtask

  // div in X; rdy raised during START must be ignored; D holds a dependent op
  task automatic test_div;
    int mult_pulses, div_pulses, stall_cycles, bdx_cycles;
    mult_pulses = 0; div_pulses = 0; stall_cycles = 0; bdx_cycles = 0;
    aluop_X = 5'b00111; rd_X = 5'd3; rs_D = 5'd3; rt_D = 5'd3;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc == 6) begin aluop_X = 5'd0; rd_X = 5'd0; end
      multdiv_rdy = (cyc == 1) || (cyc == 4);
      #1;
      if (stall_front) stall_cycles++;
      if (bubble_DX) bdx_cycles++;
      if (ctrl_MULT) mult_pulses++;
      if (ctrl_DIV) div_pulses++;
      tick();
    end
    checks++;
    if (div_pulses != 1 || mult_pulses != 0) begin
      failures++;
      $display("FAIL div_pulse got=div%0d mul%0d expected=div1 mul0", div_pulses, mult_pulses);
    end
    // detect, START, WAIT x3 (rdy on the 3rd) -> 5 stalled cycles
    checks++;
    if (stall_cycles != 5) begin
      failures++;
      $display("FAIL div_freeze_len got=%0d expected=5", stall_cycles);
    end
    checks++;
    if (bdx_cycles != 0) begin
      failures++;
      $display("FAIL div_no_bubble_DX got=%0d expected=0", bdx_cycles);
    end
    clear_inputs();
  endtask

  task automatic test_timeout;
    int stall_cycles;
    int cyc;
    stall_cycles = 0;
    cyc = 0;
    aluop_X = 5'b00110;
    #1;
    while (stall_front && cyc < 60) begin
      stall_cycles++;
      if (cyc == 41) begin
        checks++;
        if (timeout_err !== 1'b0) begin
          failures++;
          $display("FAIL timeout_early got=%b expected=0", timeout_err);
        end
      end
      tick();
      cyc++;
    end
    checks++;
    if (stall_cycles != 42) begin
      failures++;
      $display("FAIL timeout_release got=%0d expected=42", stall_cycles);
    end
    checks++;
    if ({timeout_err, md_busy} !== 2'b11) begin
      failures++;
      $display("FAIL timeout_done got=%b expected=11", {timeout_err, md_busy});
    end
    aluop_X = 5'd0;
    tick(); tick(); tick();
    checks++;
    if ({timeout_err, md_busy} !== 2'b10) begin
      failures++;
      $display("FAIL timeout_sticky got=%b expected=10", {timeout_err, md_busy});
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_wait;
    aluop_X = 5'b00111;
    tick(); tick(); tick(); tick();  // detect, START, two WAIT cycles
    checks++;
    if ({md_busy, stall_front} !== 2'b11) begin
      failures++;
      $display("FAIL rst_wait_setup got=%b expected=11", {md_busy, stall_front});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({stall_front, stall_DX, bubble_DX, bubble_XM, ctrl_MULT, ctrl_DIV, md_busy, timeout_err} !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_wait got=%b expected=00000000",
               {stall_front, stall_DX, bubble_DX, bubble_XM, ctrl_MULT, ctrl_DIV, md_busy, timeout_err});
    end
    tick();
    clear_inputs();
    reset = 1'b0;
    tick();
    checks++;
    if ({stall_front, md_busy, timeout_err} !== 3'b000) begin
      failures++;
      $display("FAIL rst_after got=%b expected=000", {stall_front, md_busy, timeout_err});
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_flush();
    test_mul();
    test_div();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
